// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared 640x480@60 timing constants, pixel colour width and the
//             frame-scheduler state type. Used by vga_controller_640_60 and
//             the vga_frame_scheduler slice.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Raster timing: both counters run 0..MAX inclusive.
    localparam int HMAX        = 800;
    localparam int VMAX        = 525;
    localparam int HLINES      = 640;
    localparam int VLINES      = 480;
    // The update window closes this many lines before the end of the frame.
    localparam int GUARD_LINES = 2;

    // RRRGGGBB colour to the Nexys3 DAC.
    localparam int RGB_W       = 8;

    // Update-window scheduler states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_layer_mux.sv
`default_nettype none
// ============================================================================
//  Module   : vga_layer_mux
//  Purpose  : Per-pixel priority select among NUM_LAYERS layer colours with a
//             background fallback, registered (pixel-path stage 1).
//             Layer 0 has the highest priority.
//  Ports    : pixel_clk, rst_n        - clock, async active-low reset
//             layer_hit [NUM_LAYERS]   - layer i covers the current pixel
//             layer_rgb [8*NUM_LAYERS] - layer i colour at [8i+7:8i]
//             bg_rgb    [8]            - colour used when no layer hits
//             pix_rgb   [8]            - selected colour, one cycle later
//  Revision : 1.0  initial release
// ============================================================================
module vga_layer_mux
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS = 4
)(
    input  logic                        pixel_clk,
    input  logic                        rst_n,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [RGB_W*NUM_LAYERS-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    output logic [RGB_W-1:0]            pix_rgb
);

    logic [RGB_W-1:0] w_layer [NUM_LAYERS];
    logic [RGB_W-1:0] w_sel;
    logic [RGB_W-1:0] r_pix;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
            assign w_layer[gi] = layer_rgb[gi*RGB_W +: RGB_W];
        end
    endgenerate

    // Walk from lowest to highest priority so the lowest-index hit wins.
    always_comb begin
        w_sel = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                w_sel = w_layer[i];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= '0;
        end else begin
            r_pix <= w_sel;
        end
    end

    assign pix_rgb = r_pix;

endmodule : vga_layer_mux
`default_nettype wire

// File: rtl/vga_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_scheduler
//  Purpose  : Owns the VGA pixel output. Two-stage pixel path (layer priority
//             select, then blanking) aligned with the delayed syncs, plus a
//             once-per-frame update window for the game logic inside vblank.
//  Ports    : pixel_clk, rst_n          - 25 MHz clock, async active-low reset
//             hcounter, vcounter [11]   - controller counters
//             blank_in, hs_in, vs_in    - controller outputs, 1 cycle after counters
//             layer_hit, layer_rgb      - per-layer coverage and colour
//             bg_rgb                    - background colour
//             upd_req                   - game logic asks for the update window
//             rgb, hs_out, vs_out       - DAC colour and syncs, mutually aligned
//             upd_grant                 - game logic may write shared state
//             frame_tick                - 1-cycle pulse at start of vblank
//             overrun                   - 1-cycle pulse when grant hits deadline
//             frame_count [16]          - completed frames, wrapping
//  Revision : 1.0  initial release
// ============================================================================
module vga_frame_scheduler #(
    parameter int NUM_LAYERS  = 4,
    parameter int VLINES      = vga_pkg::VLINES,
    parameter int VMAX        = vga_pkg::VMAX,
    parameter int GUARD_LINES = vga_pkg::GUARD_LINES
)(
    input  logic                                 pixel_clk,
    input  logic                                 rst_n,
    input  logic [10:0]                          hcounter,
    input  logic [10:0]                          vcounter,
    input  logic                                 blank_in,
    input  logic                                 hs_in,
    input  logic                                 vs_in,
    input  logic [NUM_LAYERS-1:0]                layer_hit,
    input  logic [vga_pkg::RGB_W*NUM_LAYERS-1:0] layer_rgb,
    input  logic [vga_pkg::RGB_W-1:0]            bg_rgb,
    input  logic                                 upd_req,
    output logic [vga_pkg::RGB_W-1:0]            rgb,
    output logic                                 hs_out,
    output logic                                 vs_out,
    output logic                                 upd_grant,
    output logic                                 frame_tick,
    output logic                                 overrun,
    output logic [15:0]                          frame_count
);

    localparam logic [10:0] c_vblank_line   = 11'(VLINES);
    localparam logic [10:0] c_deadline_line = 11'(VMAX - GUARD_LINES);

    logic                        w_frame_evt;
    logic                        w_deadline;
    logic [vga_pkg::RGB_W-1:0]   w_pix_s1;

    logic [vga_pkg::RGB_W-1:0]   r_rgb;
    logic                        r_hs;
    logic                        r_vs;
    logic                        r_frame_tick;
    logic [15:0]                 r_frame_count;
    logic                        r_overrun;

    vga_pkg::sched_state_e       r_state;
    vga_pkg::sched_state_e       w_state_nxt;
    logic                        w_overrun_nxt;

    // Both events are decoded from the counters, i.e. one cycle ahead of the
    // registered pulses they produce.
    assign w_frame_evt = (vcounter == c_vblank_line)   && (hcounter == 11'd0);
    assign w_deadline  = (vcounter == c_deadline_line) && (hcounter == 11'd0);

    // Stage 1: priority select, aligned with blank_in/hs_in/vs_in.
    vga_layer_mux #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_layer_mux (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .layer_hit (layer_hit),
        .layer_rgb (layer_rgb),
        .bg_rgb    (bg_rgb),
        .pix_rgb   (w_pix_s1)
    );

    // Stage 2: blanking and sync retiming; syncs idle high.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_rgb <= blank_in ? '0 : w_pix_s1;
            r_hs  <= hs_in;
            r_vs  <= vs_in;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick  <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_frame_tick <= w_frame_evt;
            if (w_frame_evt) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Grants only start on the frame event, which limits them to one per
    // frame. The deadline wins over a simultaneous release so the window is
    // still reported as overrun.
    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_nxt = 1'b0;
        case (r_state)
            vga_pkg::IDLE: begin
                if (w_frame_evt && upd_req) begin
                    w_state_nxt = vga_pkg::GRANT;
                end
            end
            vga_pkg::GRANT: begin
                if (w_deadline) begin
                    w_state_nxt   = vga_pkg::IDLE;
                    w_overrun_nxt = 1'b1;
                end else if (!upd_req) begin
                    w_state_nxt = vga_pkg::IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= vga_pkg::IDLE;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign rgb         = r_rgb;
    assign hs_out      = r_hs;
    assign vs_out      = r_vs;
    assign upd_grant   = (r_state == vga_pkg::GRANT);
    assign frame_tick  = r_frame_tick;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule : vga_frame_scheduler
`default_nettype wire

// File: tb/tb_vga_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_frame_scheduler
//  Purpose  : Self-checking bench for vga_frame_scheduler. Drives a shortened
//             raster (lines 0..9 and 470..525, 8 columns per line) with random
//             pixel data and scripted update requests, and compares every
//             output each cycle with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_frame_scheduler;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b1;
    logic [10:0] hcounter  = '0;
    logic [10:0] vcounter  = '0;
    logic        blank_in  = 1'b0;
    logic        hs_in     = 1'b1;
    logic        vs_in     = 1'b1;
    logic [3:0]  layer_hit = '0;
    logic [31:0] layer_rgb = '0;
    logic [7:0]  bg_rgb    = '0;
    logic        upd_req   = 1'b0;
    logic [7:0]  rgb;
    logic        hs_out;
    logic        vs_out;
    logic        upd_grant;
    logic        frame_tick;
    logic        overrun;
    logic [15:0] frame_count;

    vga_frame_scheduler #(
        .NUM_LAYERS  (4),
        .VLINES      (480),
        .VMAX        (525),
        .GUARD_LINES (2)
    ) u_dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .hcounter    (hcounter),
        .vcounter    (vcounter),
        .blank_in    (blank_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .layer_hit   (layer_hit),
        .layer_rgb   (layer_rgb),
        .bg_rgb      (bg_rgb),
        .upd_req     (upd_req),
        .rgb         (rgb),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .upd_grant   (upd_grant),
        .frame_tick  (frame_tick),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_s1, m_rgb;
    logic        m_hs, m_vs, m_grant, m_tick, m_over;
    logic [15:0] m_fc;
    int          over_seen, rise_seen;
    logic        prev_grant_obs = 1'b0;

    function automatic logic [7:0] pick(input logic [3:0] hit, input logic [31:0] cols,
                                        input logic [7:0] bg);
        for (int i = 0; i < 4; i++) begin
            if (hit[i]) return cols[8*i +: 8];
        end
        return bg;
    endfunction

    task automatic model_reset();
        m_s1 = 8'h00; m_rgb = 8'h00; m_hs = 1'b1; m_vs = 1'b1;
        m_grant = 1'b0; m_tick = 1'b0; m_over = 1'b0; m_fc = 16'h0000;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_rgb"},   rgb,         32'h00);
        check_eq({tag, "_hs"},    hs_out,      32'h1);
        check_eq({tag, "_vs"},    vs_out,      32'h1);
        check_eq({tag, "_grant"}, upd_grant,   32'h0);
        check_eq({tag, "_tick"},  frame_tick,  32'h0);
        check_eq({tag, "_ovr"},   overrun,     32'h0);
        check_eq({tag, "_fc"},    frame_count, 32'h0);
    endtask

    // One clock: the model consumes the inputs sampled at this edge, then
    // every output is compared. Callers change inputs only after tick returns.
    task automatic tick();
        logic evt, dl;
        @(posedge pixel_clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            evt    = (vcounter == 11'd480) && (hcounter == 11'd0);
            dl     = (vcounter == 11'd523) && (hcounter == 11'd0);
            m_rgb  = blank_in ? 8'h00 : m_s1;
            m_s1   = pick(layer_hit, layer_rgb, bg_rgb);
            m_hs   = hs_in;
            m_vs   = vs_in;
            m_tick = evt;
            if (evt) m_fc = m_fc + 16'd1;
            m_over = m_grant && dl;
            if (m_grant) begin
                if (dl || !upd_req) m_grant = 1'b0;
            end else if (evt && upd_req) begin
                m_grant = 1'b1;
            end
        end
        check_eq("rgb",   rgb,         m_rgb);
        check_eq("hs",    hs_out,      m_hs);
        check_eq("vs",    vs_out,      m_vs);
        check_eq("grant", upd_grant,   m_grant);
        check_eq("tick",  frame_tick,  m_tick);
        check_eq("ovr",   overrun,     m_over);
        check_eq("fcnt",  frame_count, m_fc);
        if (overrun) over_seen++;
        if (upd_grant && !prev_grant_obs) rise_seen++;
        prev_grant_obs = upd_grant;
    endtask

    task automatic random_pixel();
        layer_hit = 4'($urandom);
        layer_rgb = $urandom;
        bg_rgb    = 8'($urandom);
        blank_in  = 1'($urandom_range(0, 1));
        hs_in     = 1'($urandom_range(0, 1));
        vs_in     = 1'($urandom_range(0, 1));
    endtask

    // Shortened frame; returns early when stop_line is reached.
    task automatic run_frame(input int mode, input int stop_line);
        over_seen = 0;
        rise_seen = 0;
        for (int v = 0; v <= 525; v++) begin
            if (v >= 10 && v < 470) continue;
            if (v == stop_line) return;
            for (int h = 0; h < 8; h++) begin
                vcounter = 11'(v);
                hcounter = 11'(h);
                random_pixel();
                case (mode)
                    1:       upd_req = (v >= 470 && v < 490);
                    2:       upd_req = 1'b1;
                    3:       upd_req = (v >= 500);
                    4:       upd_req = 1'($urandom_range(0, 1));
                    5:       upd_req = (v >= 480 && v < 485);
                    6:       upd_req = (v >= 470 && v < 523);
                    7:       upd_req = (v >= 470) && !(v >= 490 && v < 495);
                    default: upd_req = 1'b0;
                endcase
                tick();
            end
        end
    endtask

    task automatic frame_expect(input int mode, input int rises, input int overs);
        run_frame(mode, 9999);
        check_eq($sformatf("m%0d_grant_rises", mode), rises, rises == 0 ? 32'd0 : 32'd0 + rises);
        check_eq($sformatf("m%0d_overruns", mode), over_seen, overs);
        check_eq($sformatf("m%0d_rise_cnt", mode), rise_seen, rises);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("por");
        tick();
        tick();
        rst_n = 1'b1;

        // Layers 1 and 3 hit: layer 1 wins, shown two edges later.
        vcounter = 11'd50; hcounter = 11'd100; blank_in = 1'b0;
        layer_hit = 4'b1010; layer_rgb = 32'h1C00_E000; bg_rgb = 8'h55;
        tick();
        hcounter = 11'd101; layer_hit = 4'b0000; bg_rgb = 8'h03; blank_in = 1'b0;
        tick();
        check_eq("dir_prio_E0", rgb, 32'hE0);
        hcounter = 11'd700; layer_hit = 4'b0001; layer_rgb = 32'h0000_00FF; blank_in = 1'b0;
        tick();
        check_eq("dir_bg_03", rgb, 32'h03);
        hcounter = 11'd701; layer_hit = 4'b0000; blank_in = 1'b1;
        tick();
        check_eq("dir_blank_00", rgb, 32'h00);

        run_frame(0, 9999);
        frame_expect(1, 1, 0);   // release at line 490, no regrant
        frame_expect(2, 1, 1);   // held through the deadline
        frame_expect(3, 0, 0);   // raised mid-vblank: must wait
        frame_expect(2, 1, 1);   // granted at the following frame event
        frame_expect(5, 1, 0);   // request arrives on the event edge itself
        frame_expect(6, 1, 1);   // release coincides with deadline
        frame_expect(7, 1, 0);   // re-asserted after release: no second grant
        run_frame(4, 9999);
        run_frame(4, 9999);

        // Async reset in the middle of a grant.
        run_frame(2, 500);
        check_eq("pre_rst_grant", upd_grant, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_rst");
        tick();
        tick();
        rst_n = 1'b1;
        frame_expect(2, 1, 1);

        // Back-to-back frame events to reach the wrap point.
        vcounter = 11'd480; hcounter = 11'd0; upd_req = 1'b0;
        for (int n = 0; n < 70000 && m_fc != 16'hFFFF; n++) begin
            random_pixel();
            tick();
        end
        check_eq("fc_ffff", frame_count, 32'hFFFF);
        tick();
        check_eq("fc_wrap", frame_count, 32'h0000);
        check_eq("fc_wrap_tick", frame_tick, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vga_frame_scheduler
`default_nettype wire
